// File: rtl/conv_window_gen_if.sv
// Handshake bundle for conv_window_gen: raster pixel stream in, 3x3 window stream out.
// With CONV_WINDOW_GEN_SOF_EN defined, pix_sof travels alongside pix_data.
interface conv_window_gen_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic               pix_valid;
  logic               pix_ready;
  logic [PIX_W-1:0]   pix_data;
`ifdef CONV_WINDOW_GEN_SOF_EN
  logic               pix_sof;
`endif
  logic               win_valid;
  logic               win_ready;
  logic [9*PIX_W-1:0] win_data;
  logic [RW-1:0]      win_row;
  logic [CW-1:0]      win_col;
  logic               win_last;

`ifdef CONV_WINDOW_GEN_SOF_EN
  modport master (
    output pix_valid, pix_data, pix_sof, win_ready,
    input  pix_ready, win_valid, win_data, win_row, win_col, win_last
  );
  modport slave (
    input  pix_valid, pix_data, pix_sof, win_ready,
    output pix_ready, win_valid, win_data, win_row, win_col, win_last
  );
`else
  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, win_row, win_col, win_last
  );
  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, win_row, win_col, win_last
  );
`endif
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a shift window, one tap vector per window.
// Optional CONV_WINDOW_GEN_SOF_EN adds pix_sof counter resync and a sticky frame_err flag.
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
) (
  input  logic clk,
  input  logic reset,
`ifdef CONV_WINDOW_GEN_SOF_EN
  output logic frame_err,
`endif
  conv_window_gen_if.slave io
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  typedef logic [2:0][2:0][PIX_W-1:0] taps_t;  // [r][c], flattens to tap 3*r+c
  typedef struct packed {
    logic          last;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    taps_t         taps;
  } win_t;

  logic [CW-1:0]    col, cur_col;
  logic [RW-1:0]    row, cur_row;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  // Only the two older window columns need storage; the newest comes straight from the input path.
  logic [2:0][1:0][PIX_W-1:0] hist;
  logic [2:0][PIX_W-1:0]      new_col;
  taps_t nxt_taps;
  win_t  win_q;
  logic  win_v, xfer, done;

  assign io.pix_ready = !win_v || io.win_ready;
  assign xfer         = io.pix_valid && io.pix_ready;

`ifdef CONV_WINDOW_GEN_SOF_EN
  assign cur_col = io.pix_sof ? '0 : col;
  assign cur_row = io.pix_sof ? '0 : row;
`else
  assign cur_col = col;
  assign cur_row = row;
`endif

  assign done = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  assign new_col[0] = lb1[cur_col];
  assign new_col[1] = lb0[cur_col];
  assign new_col[2] = io.pix_data;

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign nxt_taps[r] = {new_col[r], hist[r][1], hist[r][0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (cur_col == COL_MAX) begin
        col <= '0;
        row <= (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Storage is never read before rewrite, so it carries no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb0[cur_col] <= io.pix_data;
      lb1[cur_col] <= lb0[cur_col];
      for (int r = 0; r < 3; r++) begin
        hist[r][0] <= hist[r][1];
        hist[r][1] <= new_col[r];
      end
    end
  end

  // A completing transfer always overwrites the output; it can only occur when the slot is free or draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_v <= 1'b0;
      win_q <= '0;
    end else if (xfer && done) begin
      win_v      <= 1'b1;
      win_q.taps <= nxt_taps;
      win_q.row  <= cur_row - RW'(2);
      win_q.col  <= cur_col - CW'(2);
      win_q.last <= (cur_row == ROW_MAX) && (cur_col == COL_MAX);
    end else if (io.win_ready) begin
      win_v <= 1'b0;
    end
  end

`ifdef CONV_WINDOW_GEN_SOF_EN
  always_ff @(posedge clk) begin
    if (reset)
      frame_err <= 1'b0;
    else if (xfer && io.pix_sof && (col != '0 || row != '0))
      frame_err <= 1'b1;
  end
`endif

  assign io.win_valid = win_v;
  assign io.win_data  = win_q.taps;
  assign io.win_row   = win_q.row;
  assign io.win_col   = win_q.col;
  assign io.win_last  = win_q.last;
endmodule
